// File: rtl/ysyx_25030081_exu.sv
// Execute stage: drives the ALU, resolves branches/jumps and registers the result behind a valid/ready skid.
// Optional perf counters are enabled with the macro YSYX_25030081_EXU_PERF_EN.
module ysyx_25030081_exu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_src1,
  input  logic [DATA_WIDTH-1:0] in_src2,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [3:0]            in_alu_op,
  input  logic                  in_op1_sel,
  input  logic                  in_op2_sel,
  input  logic                  in_unsigned_cmp,
  input  logic [2:0]            in_br_type,
  input  logic [4:0]            in_rd,
  input  logic                  in_wen,
  output logic [3:0]            alu_op,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic                  alu_unsigned_cmp,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_zero,
  input  logic                  alu_less,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [DATA_WIDTH-1:0] out_target,
  output logic [4:0]            out_rd,
  output logic                  out_wen,
`ifdef YSYX_25030081_EXU_PERF_EN
  output logic [31:0]           perf_issue_cnt,
  output logic [31:0]           perf_stall_cnt,
`endif
  output logic                  out_redirect
);

  logic                  r_valid;
  logic                  r_redirect;
  logic                  r_wen;
  logic [4:0]            r_rd;
  logic [DATA_WIDTH-1:0] r_result;
  logic [DATA_WIDTH-1:0] r_target;

  logic                  w_capture;
  logic                  w_taken;
  logic [DATA_WIDTH-1:0] w_target;
  logic [DATA_WIDTH-1:0] w_result;
  logic [DATA_WIDTH-1:0] w_pc_plus4;

  assign alu_op           = in_alu_op;
  assign alu_op1          = in_op1_sel ? in_pc  : in_src1;
  assign alu_op2          = in_op2_sel ? in_imm : in_src2;
  assign alu_unsigned_cmp = in_unsigned_cmp;

  assign in_ready  = !rst && !flush && (!r_valid || out_ready);
  assign w_capture = in_valid && in_ready;

  assign w_pc_plus4 = in_pc + DATA_WIDTH'(4);
  assign w_result   = (in_br_type == 3'd5 || in_br_type == 3'd6) ? w_pc_plus4 : alu_out;

  always_comb begin
    w_taken  = 1'b0;
    w_target = '0;
    case (in_br_type)
      3'd1: begin w_taken = alu_zero;  w_target = in_pc + in_imm; end
      3'd2: begin w_taken = !alu_zero; w_target = in_pc + in_imm; end
      3'd3: begin w_taken = alu_less;  w_target = in_pc + in_imm; end
      3'd4: begin w_taken = !alu_less; w_target = in_pc + in_imm; end
      3'd5: begin w_taken = 1'b1;      w_target = in_pc + in_imm; end
      // jalr target is register-relative with the low bit forced clear
      3'd6: begin
        w_taken  = 1'b1;
        w_target = (in_src1 + in_imm) & {{(DATA_WIDTH-1){1'b1}}, 1'b0};
      end
      default: begin w_taken = 1'b0; w_target = '0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_redirect <= 1'b0;
      r_wen      <= 1'b0;
      r_rd       <= '0;
      r_result   <= '0;
      r_target   <= '0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_redirect <= 1'b0;
    end else if (w_capture) begin
      r_valid    <= 1'b1;
      r_redirect <= w_taken;
      r_wen      <= in_wen && (in_rd != 5'd0);
      r_rd       <= in_rd;
      r_result   <= w_result;
      r_target   <= w_target;
    end else if (out_ready) begin
      r_valid    <= 1'b0;
      r_redirect <= 1'b0;
    end
  end

  assign out_valid    = r_valid;
  assign out_redirect = r_redirect;
  assign out_wen      = r_wen;
  assign out_rd       = r_rd;
  assign out_result   = r_result;
  assign out_target   = r_target;

`ifdef YSYX_25030081_EXU_PERF_EN
  logic [31:0] r_issue_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_capture)            r_issue_cnt <= r_issue_cnt + 32'd1;
      if (r_valid && !out_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_issue_cnt = r_issue_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ysyx_25030081_exu.sv
// Directed self-checking bench for ysyx_25030081_exu; a small ALU model closes the ALU loop.
`timescale 1ns/1ps
module tb_ysyx_25030081_exu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_src1, in_src2, in_imm;
  logic [3:0]  in_alu_op;
  logic        in_op1_sel, in_op2_sel, in_unsigned_cmp;
  logic [2:0]  in_br_type;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic [3:0]  alu_op;
  logic [31:0] alu_op1, alu_op2;
  logic        alu_unsigned_cmp;
  logic [31:0] alu_out;
  logic        alu_zero, alu_less;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_target;
  logic [4:0]  out_rd;
  logic        out_wen, out_redirect;
`ifdef YSYX_25030081_EXU_PERF_EN
  logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // ALU model: op 0000 add, 1000 subtract, others pass op1
  always_comb begin
    case (alu_op)
      4'b0000: alu_out = alu_op1 + alu_op2;
      4'b1000: alu_out = alu_op1 - alu_op2;
      default: alu_out = alu_op1;
    endcase
    alu_zero = (alu_op1 == alu_op2);
    alu_less = alu_unsigned_cmp ? (alu_op1 < alu_op2) : ($signed(alu_op1) < $signed(alu_op2));
  end

  ysyx_25030081_exu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
    .in_alu_op(in_alu_op), .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel),
    .in_unsigned_cmp(in_unsigned_cmp), .in_br_type(in_br_type), .in_rd(in_rd), .in_wen(in_wen),
    .alu_op(alu_op), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_unsigned_cmp(alu_unsigned_cmp),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_less(alu_less), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_target(out_target),
    .out_rd(out_rd), .out_wen(out_wen),
`ifdef YSYX_25030081_EXU_PERF_EN
    .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .out_redirect(out_redirect)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_instr(input logic [31:0] pc, s1, s2, imm, input logic [3:0] op,
                           input logic o1, o2, uc, input logic [2:0] br,
                           input logic [4:0] rd, input logic wen);
    in_pc = pc; in_src1 = s1; in_src2 = s2; in_imm = imm; in_alu_op = op;
    in_op1_sel = o1; in_op2_sel = o2; in_unsigned_cmp = uc; in_br_type = br;
    in_rd = rd; in_wen = wen;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    set_instr(32'h0, 32'd1, 32'd1, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 5'd1, 1'b1);
    tick(); tick();
    n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_total++; if ({out_redirect, out_wen, out_rd, out_result, out_target} !== 71'd0)
      $display("FAIL reset_outputs got redir=%b wen=%b rd=%0d res=%h tgt=%h exp all 0",
               out_redirect, out_wen, out_rd, out_result, out_target); else n_pass++;
    in_valid = 1'b0; rst = 1'b0; #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready got %b exp 1", in_ready); else n_pass++;
  endtask

  task automatic test_add(input string tag);
    set_instr(32'h8000_0000, 32'd5, 32'd7, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 5'd3, 1'b1);
    in_valid = 1'b1; out_ready = 1'b1; #1;
    n_total++; if (alu_op1 !== 32'd5 || alu_op2 !== 32'd7)
      $display("FAIL %s_alu_ops got %h/%h exp 5/7", tag, alu_op1, alu_op2); else n_pass++;
    tick(); in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b1 || out_result !== 32'd12)
      $display("FAIL %s_result got v=%b res=%h exp v=1 res=0000000c", tag, out_valid, out_result); else n_pass++;
    n_total++; if (out_wen !== 1'b1 || out_rd !== 5'd3 || out_redirect !== 1'b0 || out_target !== 32'd0)
      $display("FAIL %s_ctrl got wen=%b rd=%0d redir=%b tgt=%h exp 1/3/0/0", tag, out_wen, out_rd, out_redirect, out_target); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL %s_drain got %b exp 0", tag, out_valid); else n_pass++;
  endtask

  task automatic test_branches();
    out_ready = 1'b1; in_valid = 1'b1;
    set_instr(32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'h10, 4'b1000, 1'b0, 1'b0, 1'b0, 3'd3, 5'd0, 1'b0);
    tick();
    n_total++; if (out_redirect !== 1'b1 || out_target !== 32'h8000_0010 || out_result !== 32'hFFFF_FFFE)
      $display("FAIL blt_signed got redir=%b tgt=%h res=%h exp 1/80000010/fffffffe", out_redirect, out_target, out_result); else n_pass++;
    in_unsigned_cmp = 1'b1;
    tick();
    n_total++; if (out_valid !== 1'b1 || out_redirect !== 1'b0 || out_target !== 32'h8000_0010)
      $display("FAIL bltu got v=%b redir=%b tgt=%h exp 1/0/80000010", out_valid, out_redirect, out_target); else n_pass++;
    set_instr(32'h100, 32'd9, 32'd9, 32'hFFFF_FFF8, 4'b1000, 1'b0, 1'b0, 1'b0, 3'd1, 5'd0, 1'b0);
    tick();
    n_total++; if (out_redirect !== 1'b1 || out_target !== 32'h0F8)
      $display("FAIL beq_taken got redir=%b tgt=%h exp 1/000000f8", out_redirect, out_target); else n_pass++;
    in_br_type = 3'd2;
    tick();
    n_total++; if (out_redirect !== 1'b0) $display("FAIL bne_not_taken got %b exp 0", out_redirect); else n_pass++;
    set_instr(32'h100, 32'd3, 32'd9, 32'h0, 4'b1000, 1'b0, 1'b0, 1'b0, 3'd4, 5'd0, 1'b0);
    tick();
    n_total++; if (out_redirect !== 1'b0 || out_target !== 32'h100)
      $display("FAIL bge_not_taken got redir=%b tgt=%h exp 0/00000100", out_redirect, out_target); else n_pass++;
    set_instr(32'h100, 32'd3, 32'd9, 32'h20, 4'b0000, 1'b1, 1'b1, 1'b0, 3'd5, 5'd1, 1'b1);
    tick();
    n_total++; if (out_redirect !== 1'b1 || out_target !== 32'h120 || out_result !== 32'h104 || out_wen !== 1'b1)
      $display("FAIL jal got redir=%b tgt=%h res=%h wen=%b exp 1/120/104/1", out_redirect, out_target, out_result, out_wen); else n_pass++;
    set_instr(32'h8000_0100, 32'h8000_0203, 32'd0, 32'd4, 4'b0000, 1'b0, 1'b1, 1'b0, 3'd6, 5'd1, 1'b1);
    tick();
    n_total++; if (out_redirect !== 1'b1 || out_target !== 32'h8000_0206 || out_result !== 32'h8000_0104)
      $display("FAIL jalr got redir=%b tgt=%h res=%h exp 1/80000206/80000104", out_redirect, out_target, out_result); else n_pass++;
    set_instr(32'h100, 32'd3, 32'd4, 32'h40, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd7, 5'd2, 1'b1);
    tick();
    n_total++; if (out_redirect !== 1'b0 || out_target !== 32'd0 || out_result !== 32'd7)
      $display("FAIL brtype7 got redir=%b tgt=%h res=%h exp 0/0/7", out_redirect, out_target, out_result); else n_pass++;
    in_valid = 1'b0;
    tick();
    n_total++; if (out_valid !== 1'b0 || out_redirect !== 1'b0)
      $display("FAIL branch_drain got v=%b redir=%b exp 0/0", out_valid, out_redirect); else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] stall0;
`ifdef YSYX_25030081_EXU_PERF_EN
    stall0 = perf_stall_cnt;
`else
    stall0 = 32'd0;
`endif
    out_ready = 1'b1; in_valid = 1'b1;
    set_instr(32'h0, 32'd1, 32'd2, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 5'd4, 1'b1);
    tick();
    out_ready = 1'b0;
    set_instr(32'h0, 32'd10, 32'd20, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 5'd5, 1'b1);
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %b exp 0", in_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (out_valid !== 1'b1 || out_result !== 32'd3 || out_rd !== 5'd4 || in_ready !== 1'b0)
        $display("FAIL stall_hold%0d got v=%b res=%h rd=%0d rdy=%b exp 1/3/4/0", i, out_valid, out_result, out_rd, in_ready); else n_pass++;
    end
`ifdef YSYX_25030081_EXU_PERF_EN
    n_total++; if (perf_stall_cnt - stall0 !== 32'd3)
      $display("FAIL perf_stall got %0d exp 3", perf_stall_cnt - stall0); else n_pass++;
`endif
    out_ready = 1'b1; #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL unstall_ready got %b exp 1", in_ready); else n_pass++;
    tick(); in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b1 || out_result !== 32'd30 || out_rd !== 5'd5)
      $display("FAIL stall_next got v=%b res=%h rd=%0d exp 1/1e/5", out_valid, out_result, out_rd); else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b1; in_valid = 1'b1;
    set_instr(32'h200, 32'd6, 32'd6, 32'h8, 4'b1000, 1'b0, 1'b0, 1'b0, 3'd1, 5'd0, 1'b0);
    tick();
    n_total++; if (out_redirect !== 1'b1) $display("FAIL flush_setup got %b exp 1", out_redirect); else n_pass++;
    out_ready = 1'b0; flush = 1'b1;
    set_instr(32'h0, 32'd1, 32'd1, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 5'd6, 1'b1);
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b exp 0", in_ready); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0 || out_redirect !== 1'b0)
      $display("FAIL flush_stalled got v=%b redir=%b exp 0/0", out_valid, out_redirect); else n_pass++;
    out_ready = 1'b1;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL flush_beats_capture got %b exp 0", out_valid); else n_pass++;
    flush = 1'b0; in_valid = 1'b0;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL flush_nothing_captured got %b exp 0", out_valid); else n_pass++;
    in_valid = 1'b1;
    set_instr(32'h0, 32'd1, 32'd1, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b1);
    tick(); in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b1 || out_wen !== 1'b0 || out_result !== 32'd2)
      $display("FAIL rd0_wen got v=%b wen=%b res=%h exp 1/0/2", out_valid, out_wen, out_result); else n_pass++;
    tick();
  endtask

  task automatic test_rst_stall();
    out_ready = 1'b1; in_valid = 1'b1;
    set_instr(32'h300, 32'd2, 32'd2, 32'h40, 4'b1000, 1'b0, 1'b0, 1'b0, 3'd1, 5'd7, 1'b1);
    tick();
    out_ready = 1'b0;
    tick();
    rst = 1'b1; flush = 1'b1; #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", in_ready); else n_pass++;
    tick();
    n_total++; if ({out_valid, out_redirect, out_wen, out_rd, out_result, out_target} !== 72'd0)
      $display("FAIL rst_stall_outputs got v=%b redir=%b wen=%b rd=%0d res=%h tgt=%h exp all 0",
               out_valid, out_redirect, out_wen, out_rd, out_result, out_target); else n_pass++;
`ifdef YSYX_25030081_EXU_PERF_EN
    n_total++; if (perf_issue_cnt !== 32'd0 || perf_stall_cnt !== 32'd0)
      $display("FAIL rst_perf got %0d/%0d exp 0/0", perf_issue_cnt, perf_stall_cnt); else n_pass++;
`endif
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    test_add("post_rst");
`ifdef YSYX_25030081_EXU_PERF_EN
    n_total++; if (perf_issue_cnt !== 32'd1) $display("FAIL perf_issue got %0d exp 1", perf_issue_cnt); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_add("add");
    test_branches();
    test_stall();
    test_flush();
    test_rst_stall();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ysyx_25030081_exu.md
YSYX_25030081_EXU -- requirements
Module: ysyx_25030081_exu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  upstream (decode) holds a valid instruction.
REQ-005 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-006 SHALL have ports in_pc, in_src1, in_src2, in_imm  input  32 each  PC, rs1 value, rs2 value, immediate.
REQ-007 SHALL have port in_alu_op  input  4  ALU opcode, passed through unchanged.
REQ-008 SHALL have ports in_op1_sel, in_op2_sel, in_unsigned_cmp  input  1 each  op1: 0=src1 / 1=pc; op2: 0=src2 / 1=imm; compare signedness.
REQ-009 SHALL have port in_br_type  input  3  0 none, 1 beq, 2 bne, 3 blt(u), 4 bge(u), 5 jal, 6 jalr; 7 treated as none.
REQ-010 SHALL have ports in_rd  input  5  and  in_wen  input  1  destination register and write enable.
REQ-011 SHALL have ports alu_op  output  4, alu_op1, alu_op2  output  32, alu_unsigned_cmp  output  1  drive the ALU combinationally.
REQ-012 SHALL have ports alu_out  input  32, alu_zero, alu_less  input  1  ALU result and flags.
REQ-013 SHALL have port flush  input  1  kill the incoming and the held instruction.
REQ-014 SHALL have ports out_valid  output  1  and  out_ready  input  1  downstream handshake.
REQ-015 SHALL have ports out_result, out_target  output  32, out_rd  output  5, out_wen, out_redirect  output  1  registered results.

Function
REQ-016 SHALL drive the ALU ports from the in_* fields combinationally, every cycle, regardless of in_valid.
REQ-017 SHALL assert in_ready = !out_valid || out_ready; in_ready SHALL be low while flush=1.
REQ-018 SHALL capture the in_* fields on a cycle with in_valid && in_ready && !flush: one-cycle latency, out_valid=1 next cycle.
REQ-019 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-020 SHALL clear out_valid when out_ready=1 and nothing is captured; back-to-back capture while out_ready=1 gives full throughput.
REQ-021 SHALL register out_result = in_pc+4 for br_type 5/6, else alu_out.
REQ-022 SHALL register taken as: beq alu_zero; bne !alu_zero; blt alu_less; bge !alu_less; jal/jalr 1; other 0.
REQ-023 SHALL register out_target = in_pc+in_imm for types 1-5 and (in_src1+in_imm) with bit0 cleared for jalr, mod 2^32; out_target = 0 for non-branches.
REQ-024 SHALL set out_redirect = taken, qualified by out_valid (0 whenever out_valid=0).
REQ-025 SHALL register out_wen = in_wen && (in_rd != 0).
REQ-026 SHALL, on flush, clear out_valid and out_redirect next cycle, even if out_ready=0; flush beats a same-cycle capture.

Reset
REQ-027 SHALL, on rst, set out_valid=0, out_redirect=0, out_wen=0, out_rd=0, out_result=0, out_target=0 next edge.
REQ-028 SHALL drop an in-flight instruction when rst asserts mid-stall; rst beats flush and capture; in_ready=0 while rst=1.

Configuration
REQ-029 SHALL, with macro YSYX_25030081_EXU_PERF_EN defined, add outputs perf_issue_cnt and perf_stall_cnt (32 each): issue counts captures; stall counts cycles with out_valid && !out_ready; both wrap, cleared by rst.
REQ-030 SHALL, without YSYX_25030081_EXU_PERF_EN, omit both ports and counters; all other behaviour identical.

Verification
REQ-031 SHALL cover: add x3 (src1=5, src2=7, op 0000, rd=3, wen=1), out_ready=1 -> next cycle out_valid=1, out_result=12, out_wen=1, out_rd=3, out_redirect=0.
REQ-032 SHALL cover: blt signed, src1=0xFFFFFFFF, src2=1, op 1000, pc=0x80000000, imm=0x10 -> out_redirect=1, out_target=0x80000010; same with unsigned_cmp=1 -> out_redirect=0.
REQ-033 SHALL cover: jalr pc=0x80000100, src1=0x80000203, imm=4 -> out_result=0x80000104, out_target=0x80000206, out_redirect=1.
REQ-034 SHALL cover: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> drain, new capture same cycle; perf_stall_cnt=3 when PERF_EN.
REQ-035 SHALL cover: flush while stalled with in_valid=1 -> out_valid=0 next cycle, nothing captured; wen=1 with rd=0 -> out_wen=0.
REQ-036 SHALL cover: rst during stall -> all outputs 0 next cycle; first capture after rst release behaves as REQ-031.
